// File: rtl/clmul_seq.sv
// Sequential carry-less multiplier over GF(2)[x], MSB-first Horner evaluation.
// Optionally reduces modulo POLY on every step, which yields GF(2^W) field products.
module clmul_seq #(
  parameter int         W    = 8,
  parameter logic [W:0] POLY = 9'h11B
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            reduce,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-2:0]  y,
  output logic            busy
);

  localparam int PW = 2 * W - 1;
  localparam int CW = $clog2(W);
  localparam logic [PW-1:0] POLY_EXT = PW'(POLY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            red_reg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   shifted;
  logic [PW-1:0]   acc_next;

  // In reduce mode acc only ever holds W live bits, so after the shift
  // bit W is the single overflow bit that must be folded back with POLY.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    shifted  = {acc[PW-2:0], 1'b0};
    acc_next = '0;
    if (red_reg && shifted[W]) shifted = shifted ^ POLY_EXT;
    acc_next = shifted ^ (b_reg[cnt] ? PW'(a_reg) : '0);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      red_reg   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            red_reg  <= reduce;
            acc      <= '0;
            cnt      <= CW'(W - 1);
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          acc <= acc_next;
          if (cnt == '0) begin
            y         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // in_ready rises only after the handshake edge: no same-cycle re-accept.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clmul_seq.sv
// Self-checking bench for clmul_seq: directed table, backpressure, mid-op reset
// and a randomized back-to-back stream against a polynomial-arithmetic model.
module tb_clmul_seq;

  localparam int         W    = 8;
  localparam int         PW   = 2 * W - 1;
  localparam logic [W:0] POLY = 9'h11B;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          reduce;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] y;
  logic          busy;

  clmul_seq #(.W(W), .POLY(POLY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .reduce    (reduce),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Schoolbook carry-less product, then long division by POLY.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] z,
                                            input logic red);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (z[i]) p = p ^ (PW'(x) << i);
    if (red)
      for (int i = PW - 1; i >= W; i--)
        if (p[i]) p = p ^ (PW'(POLY) << (i - W));
    return p;
  endfunction

  typedef struct {
    logic [W-1:0]  va;
    logic [W-1:0]  vb;
    logic          vred;
    logic [PW-1:0] vy;
  } vec_t;

  // Directed single operation: checks latency, result, and post-handshake state.
  task automatic run_one(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vred,
                         input logic [PW-1:0] vy, input string name);
    int c0;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    a = va; b = vb; reduce = vred; in_valid = 1'b1; out_ready = 1'b0;
    c0 = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check({name, "_latency"}, cyc - c0, W);
    check({name, "_y"}, 32'(y), 32'(vy));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_post"}, {out_valid, in_ready, 17'(y)}, {1'b0, 1'b1, 17'(vy)});
  endtask

  // Stream monitor for the random phase.
  bit            mon_en = 1'b0;
  logic [PW-1:0] exp_q[$];
  int            acc_q[$];
  int            n_acc = 0;
  logic          prev_ov = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("rnd_spurious_valid", 1, 0);
        else                   check("rnd_latency", cyc - acc_q[0], W);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_result", 1, 0);
        end else begin
          check("rnd_y", 32'(y), 32'(exp_q.pop_front()));
          void'(acc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(a, b, reduce));
        acc_q.push_back(cyc + 1);
        n_acc++;
      end
    end
    prev_ov = out_valid;
  end

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{8'h57, 8'h83, 1'b0, 15'h2B79};
    vecs[1] = '{8'h57, 8'h83, 1'b1, 15'h00C1};
    vecs[2] = '{8'h57, 8'h13, 1'b1, 15'h00FE};
    vecs[3] = '{8'h00, 8'hA5, 1'b0, 15'h0000};
    vecs[4] = '{8'hA5, 8'h00, 1'b1, 15'h0000};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 15'h5555};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; reduce = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {in_ready, out_valid, busy, 17'(y)}, {1'b1, 1'b0, 1'b0, 17'h0});
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_one(vecs[i].va, vecs[i].vb, vecs[i].vred, vecs[i].vy,
                                        $sformatf("vec%0d", i));

    // Backpressure with inputs toggling during BUSY and DONE.
    @(negedge clk);
    a = 8'h57; b = 8'h13; reduce = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      a = W'($urandom); b = W'($urandom); reduce = 1'($urandom);
      @(negedge clk); n++;
    end
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {out_valid, in_ready, busy, 17'(y)}, {1'b1, 1'b0, 1'b1, 17'h00FE});
      a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready, 17'(y)}, {1'b0, 1'b1, 17'h00FE});
    @(negedge clk);
    check("bp_idle", {out_valid, busy}, {1'b0, 1'b0});

    // Reset in the middle of a computation.
    a = 8'h57; b = 8'h83; reduce = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midop_reset", {in_ready, out_valid, busy, 17'(y)}, {1'b1, 1'b0, 1'b0, 17'h0});
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || busy) n++;
    end
    check("no_stale_after_reset", n, 0);

    // Back-to-back random stream.
    mon_en = 1'b1;
    n = 0;
    while (n_acc < 1000 && n < 50000) begin
      @(posedge clk);
      #2;
      in_valid  = (n_acc < 1000);
      a         = W'($urandom);
      b         = W'($urandom);
      reduce    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    @(posedge clk);
    #2 in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
    check("rnd_accepted", n_acc, 1000);
    check("rnd_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
